// File: rtl/mem_agent_pkg.sv
// mem_agent_pkg: shared types and constants for the AXI4 memory exerciser.
//   state_t        - top-level FSM encoding
//   RESP_OKAY      - AXI OKAY response code
//   BURST_INCR     - AXI INCR burst type
//   CACHE_DEFAULT  - AxCACHE value (normal, non-cacheable, bufferable)
//   LFSR_POLY      - Galois LFSR feedback taps for the optional LFSR pattern
//   lfsr_next()    - one right-shifting Galois LFSR step
//   sat_inc16()    - saturating 16-bit increment for the error counter
package mem_agent_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_AR   = 3'd4,
        S_R    = 3'd5,
        S_DONE = 3'd6
    } state_t;

    localparam logic [1:0]  RESP_OKAY     = 2'b00;
    localparam logic [1:0]  BURST_INCR    = 2'b01;
    localparam logic [3:0]  CACHE_DEFAULT = 4'b0011;
    localparam logic [31:0] LFSR_POLY     = 32'h8020_0003;

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ LFSR_POLY) : (x >> 1);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mem_agent_pattern_gen.sv
// mem_agent_pattern_gen: deterministic per-beat data pattern source.
// Optional feature macro: MEM_AGENT_LFSR_EN (LFSR pattern instead of seed+k).
// Ports:
//   clk_i, rst_i  - clock, asynchronous active-high reset
//   load_i        - restart the sequence from seed_i
//   adv_i         - step to the next beat's word
//   seed_i[31:0]  - sequence seed
//   data_o        - current 32-bit word replicated across DATA_W
module mem_agent_pattern_gen
    import mem_agent_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              adv_i,
    input  logic [31:0]       seed_i,
    output logic [DATA_W-1:0] data_o
);

    logic [31:0] word_q, word_d;

    always_comb begin
        word_d = word_q;
`ifdef MEM_AGENT_LFSR_EN
        // An all-zero state would lock the LFSR, so seed 0 starts at 1.
        if (load_i)     word_d = (seed_i == 32'd0) ? 32'd1 : seed_i;
        else if (adv_i) word_d = lfsr_next(word_q);
`else
        if (load_i)     word_d = seed_i;
        else if (adv_i) word_d = word_q + 32'd1;
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) word_q <= '0;
        else       word_q <= word_d;
    end

    assign data_o = {(DATA_W/32){word_q}};

endmodule

// File: rtl/mem_agent_axi_multi.sv
// mem_agent_axi_multi: AXI4 master memory exerciser. On start it writes
// NUM_BURSTS INCR bursts of a deterministic pattern from BASE_ADDR, reads the
// region back and counts mismatching or erroring beats.
// Optional feature macro: MEM_AGENT_LFSR_EN (selects LFSR data pattern).
// Ports:
//   ACLK, ARESET        - clock, asynchronous active-high reset
//   M_AXI_AW*/W*/B*     - AXI4 write address/data/response channels
//   M_AXI_AR*/R*        - AXI4 read address/data channels
//   start_in            - start pulse, accepted only when idle
//   rd_only_in          - sampled at start; skip the write phase
//   seed_in             - pattern seed, sampled at start
//   busy_out            - pass in progress
//   done_out            - one-cycle end-of-pass pulse
//   pass_out            - no errors in the last pass; held until next start
//   err_cnt_out         - saturating error count
module mem_agent_axi_multi
    import mem_agent_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int ID_W       = 1,
    parameter int BURST_LEN  = 16,
    parameter int NUM_BURSTS = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h1000_0000
) (
    input  logic                ACLK,
    input  logic                ARESET,
    output logic [ID_W-1:0]     M_AXI_AWID,
    output logic [ADDR_W-1:0]   M_AXI_AWADDR,
    output logic [7:0]          M_AXI_AWLEN,
    output logic [2:0]          M_AXI_AWSIZE,
    output logic [1:0]          M_AXI_AWBURST,
    output logic                M_AXI_AWLOCK,
    output logic [3:0]          M_AXI_AWCACHE,
    output logic [2:0]          M_AXI_AWPROT,
    output logic [3:0]          M_AXI_AWQOS,
    output logic                M_AXI_AWUSER,
    output logic                M_AXI_AWVALID,
    input  logic                M_AXI_AWREADY,
    output logic [DATA_W-1:0]   M_AXI_WDATA,
    output logic [DATA_W/8-1:0] M_AXI_WSTRB,
    output logic                M_AXI_WLAST,
    output logic                M_AXI_WUSER,
    output logic                M_AXI_WVALID,
    input  logic                M_AXI_WREADY,
    input  logic [ID_W-1:0]     M_AXI_BID,
    input  logic [1:0]          M_AXI_BRESP,
    input  logic                M_AXI_BUSER,
    input  logic                M_AXI_BVALID,
    output logic                M_AXI_BREADY,
    output logic [ID_W-1:0]     M_AXI_ARID,
    output logic [ADDR_W-1:0]   M_AXI_ARADDR,
    output logic [7:0]          M_AXI_ARLEN,
    output logic [2:0]          M_AXI_ARSIZE,
    output logic [1:0]          M_AXI_ARBURST,
    output logic                M_AXI_ARLOCK,
    output logic [3:0]          M_AXI_ARCACHE,
    output logic [2:0]          M_AXI_ARPROT,
    output logic [3:0]          M_AXI_ARQOS,
    output logic                M_AXI_ARUSER,
    output logic                M_AXI_ARVALID,
    input  logic                M_AXI_ARREADY,
    input  logic [ID_W-1:0]     M_AXI_RID,
    input  logic [DATA_W-1:0]   M_AXI_RDATA,
    input  logic [1:0]          M_AXI_RRESP,
    input  logic                M_AXI_RLAST,
    input  logic                M_AXI_RUSER,
    input  logic                M_AXI_RVALID,
    output logic                M_AXI_RREADY,
    input  logic                start_in,
    input  logic                rd_only_in,
    input  logic [31:0]         seed_in,
    output logic                busy_out,
    output logic                done_out,
    output logic                pass_out,
    output logic [15:0]         err_cnt_out
);

    localparam int                BW          = $clog2(BURST_LEN + 1);
    localparam logic [BW-1:0]     LAST_BEAT   = BW'(BURST_LEN - 1);
    localparam logic [15:0]       LAST_BURST  = 16'(NUM_BURSTS - 1);
    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * DATA_W / 8);
    localparam logic [7:0]        AX_LEN      = 8'(BURST_LEN - 1);
    localparam logic [2:0]        AX_SIZE     = 3'($clog2(DATA_W / 8));

    state_t            state_q, state_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [15:0]       burst_q, burst_d;
    logic [ADDR_W-1:0] off_q, off_d;     // running burst offset, replaces b*BURST_BYTES
    logic [15:0]       err_q, err_d;
    logic              pass_q, pass_d;

    logic              pat_load, wr_adv, rd_adv, rd_bad;
    logic [DATA_W-1:0] wr_pat, rd_exp;

    // Sideband inputs carry nothing this agent acts on.
    logic unused_sideband;
    assign unused_sideband = ^{M_AXI_BID, M_AXI_BUSER, M_AXI_RID, M_AXI_RUSER};

    // Both generators reload from the same seed at start, so the read-back
    // expectation restarts the sequence the write phase produced.
    mem_agent_pattern_gen #(.DATA_W(DATA_W)) u_wr_pat (
        .clk_i(ACLK), .rst_i(ARESET), .load_i(pat_load), .adv_i(wr_adv),
        .seed_i(seed_in), .data_o(wr_pat)
    );

    mem_agent_pattern_gen #(.DATA_W(DATA_W)) u_rd_pat (
        .clk_i(ACLK), .rst_i(ARESET), .load_i(pat_load), .adv_i(rd_adv),
        .seed_i(seed_in), .data_o(rd_exp)
    );

    // Several faults on one beat still count once.
    assign rd_bad = (M_AXI_RDATA != rd_exp) || (M_AXI_RRESP != RESP_OKAY) ||
                    (M_AXI_RLAST != (beat_q == LAST_BEAT));

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            burst_q <= '0;
            off_q   <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            burst_q <= burst_d;
            off_q   <= off_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        burst_d  = burst_q;
        off_d    = off_q;
        err_d    = err_q;
        pass_d   = pass_q;
        pat_load = 1'b0;
        wr_adv   = 1'b0;
        rd_adv   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    pat_load = 1'b1;
                    err_d    = '0;
                    pass_d   = 1'b0;
                    beat_d   = '0;
                    burst_d  = '0;
                    off_d    = '0;
                    // Mode only steers this branch, so it needs no register.
                    state_d  = rd_only_in ? S_AR : S_AW;
                end
            end
            S_AW: if (M_AXI_AWREADY) state_d = S_W;
            S_W: begin
                if (M_AXI_WREADY) begin
                    wr_adv = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = S_B;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            S_B: begin
                if (M_AXI_BVALID) begin
                    if (M_AXI_BRESP != RESP_OKAY) err_d = sat_inc16(err_q);
                    if (burst_q == LAST_BURST) begin
                        burst_d = '0;
                        off_d   = '0;
                        state_d = S_AR;
                    end else begin
                        burst_d = burst_q + 16'd1;
                        off_d   = off_q + BURST_BYTES;
                        state_d = S_AW;
                    end
                end
            end
            S_AR: if (M_AXI_ARREADY) state_d = S_R;
            S_R: begin
                if (M_AXI_RVALID) begin
                    rd_adv = 1'b1;
                    if (rd_bad) err_d = sat_inc16(err_q);
                    // Burst length is ours, not the slave's RLAST.
                    if (beat_q == LAST_BEAT) begin
                        beat_d = '0;
                        if (burst_q == LAST_BURST) begin
                            state_d = S_DONE;
                        end else begin
                            burst_d = burst_q + 16'd1;
                            off_d   = off_q + BURST_BYTES;
                            state_d = S_AR;
                        end
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            S_DONE: begin
                pass_d  = (err_q == 16'd0);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode from registered state so reset clears them at once.
    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = (state_q == S_AW) ? BASE_ADDR + off_q : '0;
    assign M_AXI_AWLEN   = AX_LEN;
    assign M_AXI_AWSIZE  = AX_SIZE;
    assign M_AXI_AWBURST = BURST_INCR;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = CACHE_DEFAULT;
    assign M_AXI_AWPROT  = '0;
    assign M_AXI_AWQOS   = '0;
    assign M_AXI_AWUSER  = 1'b0;
    assign M_AXI_AWVALID = (state_q == S_AW);

    assign M_AXI_WDATA   = (state_q == S_W) ? wr_pat : '0;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = (state_q == S_W) && (beat_q == LAST_BEAT);
    assign M_AXI_WUSER   = 1'b0;
    assign M_AXI_WVALID  = (state_q == S_W);
    assign M_AXI_BREADY  = (state_q == S_B);

    assign M_AXI_ARID    = '0;
    assign M_AXI_ARADDR  = (state_q == S_AR) ? BASE_ADDR + off_q : '0;
    assign M_AXI_ARLEN   = AX_LEN;
    assign M_AXI_ARSIZE  = AX_SIZE;
    assign M_AXI_ARBURST = BURST_INCR;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = CACHE_DEFAULT;
    assign M_AXI_ARPROT  = '0;
    assign M_AXI_ARQOS   = '0;
    assign M_AXI_ARUSER  = 1'b0;
    assign M_AXI_ARVALID = (state_q == S_AR);
    assign M_AXI_RREADY  = (state_q == S_R);

    assign busy_out    = (state_q != S_IDLE);
    assign done_out    = (state_q == S_DONE);
    assign pass_out    = (state_q == S_DONE) ? (err_q == 16'd0) : pass_q;
    assign err_cnt_out = err_q;

endmodule

// File: tb/tb_mem_agent_axi_multi.sv
// Bench for mem_agent_axi_multi: AXI slave model with memory and fault
// knobs, plus an expected-pattern model derived from seed and beat index.
module tb_mem_agent_axi_multi;

    localparam int          DW    = 64;
    localparam int          LEN   = 16;
    localparam int          NB    = 4;
    localparam int          TOTAL = LEN * NB;
    localparam logic [31:0] BASE  = 32'h1000_0000;

    logic clk = 1'b0, rst;
    always #5 clk = ~clk;

    logic        AWID, AWLOCK, AWUSER, AWVALID, AWREADY;
    logic [31:0] AWADDR, ARADDR;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, AWPROT, ARSIZE, ARPROT;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic [3:0]  AWCACHE, AWQOS, ARCACHE, ARQOS;
    logic [DW-1:0] WDATA, RDATA;
    logic [7:0]  WSTRB;
    logic        WLAST, WUSER, WVALID, WREADY;
    logic        BID, BUSER, BVALID, BREADY;
    logic        ARID, ARLOCK, ARUSER, ARVALID, ARREADY;
    logic        RID, RLAST, RUSER, RVALID, RREADY;
    logic        start_in, rd_only_in, busy_out, done_out, pass_out;
    logic [31:0] seed_in;
    logic [15:0] err_cnt_out;

    mem_agent_axi_multi dut (
        .ACLK(clk), .ARESET(rst),
        .M_AXI_AWID(AWID), .M_AXI_AWADDR(AWADDR), .M_AXI_AWLEN(AWLEN), .M_AXI_AWSIZE(AWSIZE),
        .M_AXI_AWBURST(AWBURST), .M_AXI_AWLOCK(AWLOCK), .M_AXI_AWCACHE(AWCACHE), .M_AXI_AWPROT(AWPROT),
        .M_AXI_AWQOS(AWQOS), .M_AXI_AWUSER(AWUSER), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
        .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WLAST(WLAST), .M_AXI_WUSER(WUSER),
        .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
        .M_AXI_BID(BID), .M_AXI_BRESP(BRESP), .M_AXI_BUSER(BUSER), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
        .M_AXI_ARID(ARID), .M_AXI_ARADDR(ARADDR), .M_AXI_ARLEN(ARLEN), .M_AXI_ARSIZE(ARSIZE),
        .M_AXI_ARBURST(ARBURST), .M_AXI_ARLOCK(ARLOCK), .M_AXI_ARCACHE(ARCACHE), .M_AXI_ARPROT(ARPROT),
        .M_AXI_ARQOS(ARQOS), .M_AXI_ARUSER(ARUSER), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
        .M_AXI_RID(RID), .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RLAST(RLAST), .M_AXI_RUSER(RUSER),
        .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY),
        .start_in(start_in), .rd_only_in(rd_only_in), .seed_in(seed_in),
        .busy_out(busy_out), .done_out(done_out), .pass_out(pass_out), .err_cnt_out(err_cnt_out)
    );

    int tests = 0, fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference pattern: 32-bit word for global beat k, replicated.
    function automatic logic [31:0] pat(input logic [31:0] seed, input int k);
`ifdef MEM_AGENT_LFSR_EN
        logic [31:0] x;
        x = (seed == 32'd0) ? 32'd1 : seed;
        for (int i = 0; i < k; i++) x = x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
        return x;
`else
        return seed + 32'(k);
`endif
    endfunction

    // ---------------- slave model (acts on negedge) ----------------
    logic [DW-1:0] mem [0:TOTAL-1];
    logic [31:0]   aw_list[$], ar_list[$];
    bit stall_en = 0, drop_last = 0, aw_ever = 0;
    int corrupt_k = -1, bresp_err_b = -1;
    int s_wpres = 0;

    function automatic bit go();
        return !stall_en || ($urandom_range(0, 1) == 1);
    endfunction

    initial begin
        int aw_have = 0, widx = 0, wbeat = 0, b_pend = 0, b_cnt = 0;
        int ar_have = 0, ridx = 0, rbeat = 0, k;
        bit aw_wait = 0, ar_wait = 0, w_wait = 0;
        logic [31:0] aw_prev = 0, ar_prev = 0;
        logic [DW-1:0] w_prev = 0;
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; ARREADY = 0;
        RVALID = 0; RDATA = 0; RRESP = 0; RLAST = 0;
        BID = 0; BUSER = 0; RID = 0; RUSER = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                aw_have = 0; wbeat = 0; b_pend = 0; ar_have = 0; rbeat = 0;
                aw_wait = 0; ar_wait = 0; w_wait = 0;
                AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0; RLAST = 0;
                continue;
            end
            if (start_in) begin b_cnt = 0; aw_list.delete(); ar_list.delete(); end
            if (AWVALID) aw_ever = 1;
            if (aw_wait) check("aw_hold", {AWVALID, AWADDR}, {1'b1, aw_prev});
            if (ar_wait) check("ar_hold", {ARVALID, ARADDR}, {1'b1, ar_prev});
            if (w_wait)  check("w_hold", WDATA, w_prev);
            // B
            BVALID = 0; BRESP = 2'b00;
            if (b_pend != 0 && go()) begin
                BVALID = 1;
                BRESP  = (b_cnt == bresp_err_b) ? 2'b10 : 2'b00;
            end
            if (BVALID && BREADY) begin b_pend = 0; b_cnt++; end
            // W
            WREADY = (aw_have != 0) && go();
            s_wpres = wbeat;
            w_wait = WVALID && !WREADY; w_prev = WDATA;
            if (WVALID && WREADY) begin
                mem[(widx + wbeat) % TOTAL] = WDATA;
                check("wlast", WLAST, (wbeat == LEN - 1));
                if (wbeat == LEN - 1) begin aw_have = 0; b_pend = 1; wbeat = 0; end
                else wbeat++;
            end
            // AW
            AWREADY = (aw_have == 0) && (b_pend == 0) && go();
            aw_wait = AWVALID && !AWREADY; aw_prev = AWADDR;
            if (AWVALID && AWREADY) begin
                aw_have = 1; wbeat = 0; widx = int'((AWADDR - BASE) / (DW / 8));
                aw_list.push_back(AWADDR);
            end
            // R
            RVALID = 0; RLAST = 0; RDATA = 0; RRESP = 2'b00;
            if (ar_have != 0 && go()) begin
                k = (ridx + rbeat) % TOTAL;
                RVALID = 1;
                RDATA  = mem[k] ^ ((k == corrupt_k) ? 64'd1 : 64'd0);
                RLAST  = (rbeat == LEN - 1) && !(drop_last && k == TOTAL - 1);
            end
            if (RVALID && RREADY) begin
                if (rbeat == LEN - 1) begin ar_have = 0; rbeat = 0; end
                else rbeat++;
            end
            // AR
            ARREADY = (ar_have == 0) && go();
            ar_wait = ARVALID && !ARREADY; ar_prev = ARADDR;
            if (ARVALID && ARREADY) begin
                ar_have = 1; rbeat = 0; ridx = int'((ARADDR - BASE) / (DW / 8));
                ar_list.push_back(ARADDR);
            end
        end
    end

    // ---------------- main sequence ----------------
    task automatic step();
        @(negedge clk); #2;
    endtask

    task automatic run_pass(input logic [31:0] seed, input logic rdo, input int exp_err, input string tag);
        int cyc = 0;
        bit seen = 0;
        seed_in = seed; rd_only_in = rdo; start_in = 1;
        step();
        start_in = 0;
        check({tag, "_busy"}, busy_out, 1);
        if (!rdo) check({tag, "_aw_lat"}, AWVALID, 1);
        while (!seen && cyc < 4000) begin
            if (done_out) seen = 1;
            else begin step(); cyc++; end
        end
        check({tag, "_done"}, seen, 1);
        check({tag, "_err"}, err_cnt_out, exp_err);
        check({tag, "_pass"}, pass_out, (exp_err == 0));
        step();
        check({tag, "_post"}, {done_out, busy_out, pass_out}, {2'b00, (exp_err == 0)});
    endtask

    function automatic int mem_bad(input logic [31:0] seed);
        int bad = 0;
        for (int k = 0; k < TOTAL; k++)
            if (mem[k] !== {2{pat(seed, k)}}) bad++;
        return bad;
    endfunction

    initial begin
        #400000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] s;
        int cyc;
        bit hit;
        rst = 1; start_in = 0; rd_only_in = 0; seed_in = 0;
        repeat (3) step();
        check("rst_vld", {AWVALID, WVALID, ARVALID, BREADY, RREADY}, 0);
        check("rst_stat", {busy_out, done_out, pass_out, err_cnt_out}, 0);
        check("rst_addr", {AWADDR, ARADDR}, 0);
        check("rst_wdata", WDATA, 0);
        rst = 0;
        step();

        // 1: clean pass, seed 0
        run_pass(32'd0, 1'b0, 0, "t1");
        check("t1_mem", mem_bad(32'd0), 0);
        check("t1_nbursts", aw_list.size() * 100 + ar_list.size(), NB * 101);

        // 2: one corrupted read beat
        s = $urandom;
        corrupt_k = 5;
        run_pass(s, 1'b0, 1, "t2");
        check("t2_mem", mem_bad(s), 0);
        corrupt_k = -1;

        // 3: random stalls on every channel
        s = $urandom;
        stall_en = 1;
        run_pass(s, 1'b0, 0, "t3");
        stall_en = 0;
        check("t3_naddr", aw_list.size() * 100 + ar_list.size(), NB * 101);
        for (int i = 0; i < NB; i++) begin
            if (i < aw_list.size()) check("t3_awaddr", aw_list[i], BASE + 32'(i * LEN * DW / 8));
            if (i < ar_list.size()) check("t3_araddr", ar_list[i], BASE + 32'(i * LEN * DW / 8));
        end

        // 4: SLVERR on burst 2 and missing final RLAST
        bresp_err_b = 2; drop_last = 1;
        run_pass($urandom, 1'b0, 2, "t4");
        bresp_err_b = -1; drop_last = 0;

        // 5: restart attempt mid-pass, then reset during W beat 7
        seed_in = 32'h55; rd_only_in = 0; start_in = 1;
        step();
        start_in = 0;
        repeat (2) step();
        start_in = 1; seed_in = 32'hAA;
        step();
        start_in = 0;
        check("t5_busy", busy_out, 1);
        hit = 0; cyc = 0;
        while (!hit && cyc < 200) begin
            if (WVALID && s_wpres == 7) hit = 1;
            else begin step(); cyc++; end
        end
        check("t5_beat7", hit, 1);
        rst = 1;
        #1;
        check("t5_rst_vld", {AWVALID, WVALID, ARVALID, BREADY, RREADY}, 0);
        check("t5_rst_busy", {busy_out, done_out, err_cnt_out}, 0);
        repeat (2) step();
        rst = 0;
        step();
        run_pass($urandom, 1'b0, 0, "t5b");

        // 6: read-only against preloaded memory, seed 0
        for (int k = 0; k < TOTAL; k++) mem[k] = {2{pat(32'd0, k)}};
        aw_ever = 0;
        run_pass(32'd0, 1'b1, 0, "t6");
        check("t6_no_aw", aw_ever, 0);
        check("t6_first", mem[0][31:0], pat(32'd0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
